// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size, exception and state encodings for the memory-stage LSU
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUSTO    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } lsuState_t;

  // Size code 2'b11 is handled as a word everywhere, so it shares the word rule.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_BYTE: isMisaligned = 1'b0;
      SZ_HALF: isMisaligned = addrLo[0];
      default: isMisaligned = |addrLo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian lane steering for stores and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        signedLoad,
  input  logic [31:0] storeIn,
  input  logic [31:0] readWord,
  output logic [3:0]  byteEn,
  output logic [31:0] storeLanes,
  output logic [31:0] loadValue
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Store side: replicate the datum across lanes and enable only the addressed bytes.
  always_comb begin
    byteEn     = 4'b1111;
    storeLanes = storeIn;
    case (size)
      SZ_BYTE: begin
        byteEn     = 4'b0001 << addrLo;
        storeLanes = {4{storeIn[7:0]}};
      end
      SZ_HALF: begin
        byteEn     = addrLo[1] ? 4'b1100 : 4'b0011;
        storeLanes = {2{storeIn[15:0]}};
      end
      default: begin
        byteEn     = 4'b1111;
        storeLanes = storeIn;
      end
    endcase
  end

  // Load side: pick the addressed byte/half from the read word, then zero- or sign-extend.
  always_comb begin
    byteSel   = readWord[{addrLo, 3'b000} +: 8];
    halfSel   = addrLo[1] ? readWord[31:16] : readWord[15:0];
    loadValue = readWord;
    case (size)
      SZ_BYTE: loadValue = {{24{signedLoad & byteSel[7]}}, byteSel};
      SZ_HALF: loadValue = {{16{signedLoad & halfSel[15]}}, halfSel};
      default: loadValue = readWord;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit between execute and write-back
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_mem_read,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [1:0]        wb_exc
);

  // Last WAIT count value before the bus is declared dead.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsuState_t state, stateNext;

  logic [ADDR_W-1:0] opAddr;
  logic [31:0]       opWdata;
  logic              opLoad;
  logic              opStore;
  logic [1:0]        opSize;
  logic              opSigned;
  logic              opMemToReg;
  logic              opRegWrite;
  logic [4:0]        opRd;
  logic              opKill;
  logic [7:0]        toCount;

  logic              accept;
  logic              exIsMem;
  logic              exMis;
  logic              busActive;
  logic              enteringDone;

  logic [ADDR_W-1:0] finAddr;
  logic [31:0]       finRead;
  logic              finMemToReg;
  logic              finRegWrite;
  logic [4:0]        finRd;
  logic [1:0]        finExc;
  logic              finKill;

  logic [3:0]        alignBe;
  logic [31:0]       alignStore;
  logic [31:0]       alignLoad;

  assign ex_ready     = (state == ST_IDLE);
  assign accept       = ex_valid & ex_ready;
  assign exIsMem      = ex_mem_read | ex_mem_write;
  assign exMis        = isMisaligned(ex_size, ex_addr[1:0]);
  assign busActive    = (state == ST_ISSUE) || (state == ST_WAIT);
  assign enteringDone = (stateNext == ST_DONE) && (state != ST_DONE);

  // Bus outputs come straight from the captured op so they stay stable until ack.
  assign dm_req   = busActive;
  assign dm_we    = busActive & opStore;
  assign dm_be    = busActive ? alignBe : 4'b0000;
  assign dm_addr  = {opAddr[ADDR_W-1:2], 2'b00};
  assign dm_wdata = alignStore;

  lsu_align uAlign (
    .addrLo     (opAddr[1:0]),
    .size       (opSize),
    .signedLoad (opSigned),
    .storeIn    (opWdata),
    .readWord   (dm_rdata),
    .byteEn     (alignBe),
    .storeLanes (alignStore),
    .loadValue  (alignLoad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Next state plus the write-back values to latch on the way into DONE; the
  // IDLE path reaches DONE in one step, so its fields come from execute directly.
  always_comb begin
    stateNext   = state;
    finAddr     = opAddr;
    finRead     = 32'h0;
    finMemToReg = opMemToReg;
    finRegWrite = opRegWrite;
    finRd       = opRd;
    finExc      = EXC_NONE;
    finKill     = opKill | flush;
    case (state)
      ST_IDLE: begin
        finAddr     = ex_addr;
        finMemToReg = ex_mem_to_reg;
        finRegWrite = ex_reg_write;
        finRd       = ex_rd;
        finKill     = flush;
        if (accept) begin
          if (!exIsMem) begin
            stateNext = ST_DONE;
          end else if (exMis) begin
            stateNext = ST_DONE;
            finExc    = EXC_MISALIGN;
          end else begin
            stateNext = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: stateNext = ST_WAIT;
      ST_WAIT: begin
        if (dm_ack) begin
          stateNext = ST_DONE;
          finRead   = opLoad ? alignLoad : 32'h0;
        end else if (toCount == TO_LAST) begin
          stateNext = ST_DONE;
          finExc    = EXC_BUSTO;
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Capture the accepted op, accumulate the sticky kill, and count unacknowledged WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opAddr     <= '0;
      opWdata    <= '0;
      opLoad     <= 1'b0;
      opStore    <= 1'b0;
      opSize     <= SZ_BYTE;
      opSigned   <= 1'b0;
      opMemToReg <= 1'b0;
      opRegWrite <= 1'b0;
      opRd       <= '0;
      opKill     <= 1'b0;
      toCount    <= '0;
    end else if (accept) begin
      opAddr     <= ex_addr;
      opWdata    <= ex_wdata;
      opLoad     <= ex_mem_read;
      opStore    <= ex_mem_write & ~ex_mem_read;
      opSize     <= ex_size;
      opSigned   <= ex_signed;
      opMemToReg <= ex_mem_to_reg;
      opRegWrite <= ex_reg_write;
      opRd       <= ex_rd;
      opKill     <= flush;
      toCount    <= '0;
    end else if (busActive) begin
      if (flush) opKill <= 1'b1;
      if ((state == ST_WAIT) && !dm_ack) toCount <= toCount + 8'd1;
    end
  end

  // Write-back registers: loaded once per op on entry to DONE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_mem_read   <= '0;
      wb_addr       <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_exc        <= EXC_NONE;
    end else begin
      wb_valid <= 1'b0;
      if (enteringDone) begin
        wb_valid      <= ~finKill;
        wb_mem_read   <= finRead;
        wb_addr       <= finAddr;
        wb_mem_to_reg <= finMemToReg;
        wb_reg_write  <= finRegWrite & (finExc == EXC_NONE);
        wb_rd         <= finRd;
        wb_exc        <= finExc;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_signed;
  logic        ex_mem_to_reg;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [31:0] wb_mem_read;
  logic [31:0] wb_addr;
  logic        wb_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_exc;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_addr       (ex_addr),
    .ex_wdata      (ex_wdata),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_size       (ex_size),
    .ex_signed     (ex_signed),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .flush         (flush),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_be         (dm_be),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .wb_valid      (wb_valid),
    .wb_mem_read   (wb_mem_read),
    .wb_addr       (wb_addr),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_exc        (wb_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] memRead;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  exc;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          ackWait = -1;
  logic [31:0] memWord = 32'h0;
  int          reqCnt = 0;
  int          reqTotal = 0;
  int          stableErr = 0;
  logic [31:0] snapAddr, snapWdata;
  logic [3:0]  snapBe;
  logic        snapWe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: acks after a programmed number of WAIT cycles and checks bus stability.
  initial begin
    dm_ack = 1'b0;
    dm_rdata = 32'h0BAD0BAD;
    forever begin
      @(negedge clk);
      if (dm_req) begin
        reqCnt++;
        reqTotal++;
        if (reqCnt == 1) begin
          snapAddr = dm_addr; snapBe = dm_be; snapWdata = dm_wdata; snapWe = dm_we;
        end else if (dm_addr !== snapAddr || dm_be !== snapBe || dm_wdata !== snapWdata || dm_we !== snapWe) begin
          stableErr++;
        end
        dm_ack = (ackWait >= 0) && (reqCnt == 2 + ackWait);
        dm_rdata = dm_ack ? memWord : 32'h0BAD0BAD;
      end else begin
        reqCnt = 0;
        dm_ack = 1'b0;
        dm_rdata = 32'h0BAD0BAD;
      end
    end
  end

  // Monitor: every write-back pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        if (expQ.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid), 32'h0);
        end else begin
          e = expQ.pop_front();
          check("wb_cycle", cyc, e.cyc);
          check("wb_addr", wb_addr, e.addr);
          check("wb_mem_read", wb_mem_read, e.memRead);
          check("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e.m2r));
          check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_exc", 32'(wb_exc), 32'(e.exc));
        end
      end
    end
  end

  task automatic issueOp(
    input string name, input logic [31:0] addr, input logic [31:0] wdata,
    input logic rdv, input logic wrv, input logic [1:0] size, input logic sgn,
    input logic m2r, input logic rw, input logic [4:0] rd, input logic [31:0] rdata,
    input int ackAfter, input int flushAt, input int expReq,
    input logic [31:0] expDmAddr, input logic [3:0] expBe, input logic [31:0] expDmWdata,
    input logic expWe, input logic push, input logic [31:0] expRead, input logic expRw,
    input logic [1:0] expExc, input int lat);
    exp_t e;
    bit done;
    @(negedge clk);
    check({name, "_ready"}, 32'(ex_ready), 32'h1);
    memWord = rdata; ackWait = ackAfter; reqTotal = 0; stableErr = 0;
    ex_addr = addr; ex_wdata = wdata; ex_mem_read = rdv; ex_mem_write = wrv;
    ex_size = size; ex_signed = sgn; ex_mem_to_reg = m2r; ex_reg_write = rw; ex_rd = rd;
    ex_valid = 1'b1;
    flush = (flushAt == 0);
    if (push) begin
      e.addr = addr; e.memRead = expRead; e.m2r = m2r; e.rw = expRw;
      e.rd = rd; e.exc = expExc; e.cyc = cyc + lat;
      expQ.push_back(e);
    end
    done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      flush = (i == flushAt);
      if (ex_ready) begin
        done = 1'b1;
        break;
      end
    end
    flush = 1'b0;
    check({name, "_done"}, 32'(done), 32'h1);
    check({name, "_req_cycles"}, reqTotal, expReq);
    if (expReq > 0) begin
      check({name, "_dm_addr"}, snapAddr, expDmAddr);
      check({name, "_dm_be"}, 32'(snapBe), 32'(expBe));
      check({name, "_dm_wdata"}, snapWdata, expDmWdata);
      check({name, "_dm_we"}, 32'(snapWe), 32'(expWe));
      check({name, "_dm_stable"}, stableErr, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_size = 2'b00; ex_signed = 1'b0; ex_mem_to_reg = 1'b0;
    ex_reg_write = 1'b0; ex_rd = '0; flush = 1'b0;
    #2;
    check("rst_dm_req", 32'(dm_req), 32'h0);
    check("rst_dm_we", 32'(dm_we), 32'h0);
    check("rst_dm_be", 32'(dm_be), 32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_wb_addr", wb_addr, 32'h0);
    check("rst_wb_exc", 32'(wb_exc), 32'h0);
    check("rst_ex_ready", 32'(ex_ready), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    //      name       addr          wdata         rd wr size  sg m2r rw rd  rdata         ack flu req dmAddr        be       dmWdata       we push expRead       rw exc  lat
    issueOp("wload",   32'h100,      32'h0,        1, 0, 2'b10, 0, 1, 1, 5,  32'hDEADBEEF, 0, -1, 2, 32'h100,      4'b1111, 32'h0,        0, 1, 32'hDEADBEEF, 1, 2'b00, 3);
    issueOp("lbs",     32'h103,      32'h0,        1, 0, 2'b00, 1, 1, 1, 6,  32'h80112233, 0, -1, 2, 32'h100,      4'b1000, 32'h0,        0, 1, 32'hFFFFFF80, 1, 2'b00, 3);
    issueOp("lbu",     32'h103,      32'h0,        1, 0, 2'b00, 0, 1, 1, 6,  32'h80112233, 0, -1, 2, 32'h100,      4'b1000, 32'h0,        0, 1, 32'h00000080, 1, 2'b00, 3);
    issueOp("sh",      32'h0A,       32'h0000BEEF, 0, 1, 2'b01, 0, 0, 1, 7,  32'h12345678, 1, -1, 3, 32'h08,       4'b1100, 32'hBEEFBEEF, 1, 1, 32'h0,        1, 2'b00, 4);
    issueOp("mis_lw",  32'h8BADF00E, 32'h0,        1, 0, 2'b10, 0, 1, 1, 8,  32'h0,        0, -1, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0,        0, 2'b01, 1);
    issueOp("timeout", 32'h200,      32'h0,        1, 0, 2'b10, 0, 1, 1, 9,  32'hFFFFFFFF, -1,-1, 5, 32'h200,      4'b1111, 32'h0,        0, 1, 32'h0,        0, 2'b10, 6);
    issueOp("alu",     32'h8BADF00D, 32'h0,        0, 0, 2'b10, 0, 0, 1, 10, 32'h0,        0, -1, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0,        1, 2'b00, 1);
    issueOp("fl_wait", 32'h300,      32'h0,        1, 0, 2'b10, 0, 1, 1, 11, 32'h00005555, 2,  2, 4, 32'h300,      4'b1111, 32'h0,        0, 0, 32'h0,        0, 2'b00, 0);
    issueOp("fl_acc",  32'h44,       32'h0,        0, 0, 2'b10, 0, 0, 1, 12, 32'h0,        0,  0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 32'h0,        0, 2'b00, 0);

    // Reset asserted in the middle of a WAIT with no ack coming.
    @(negedge clk);
    memWord = 32'h0; ackWait = -1;
    ex_addr = 32'h400; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_size = 2'b10;
    ex_rd = 5'd3; ex_reg_write = 1'b1; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_req_before", 32'(dm_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(dm_req), 32'h0);
    check("rst_mid_be", 32'(dm_be), 32'h0);
    check("rst_mid_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_mid_wb_addr", wb_addr, 32'h0);
    check("rst_mid_ready", 32'(ex_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    issueOp("lh_s",    32'h102,      32'h0,        1, 0, 2'b01, 1, 1, 1, 13, 32'h80017FFF, 0, -1, 2, 32'h100,      4'b1100, 32'h0,        0, 1, 32'hFFFF8001, 1, 2'b00, 3);
    issueOp("lb_l1",   32'h101,      32'h0,        1, 0, 2'b00, 1, 1, 1, 14, 32'h80112233, 0, -1, 2, 32'h100,      4'b0010, 32'h0,        0, 1, 32'h00000022, 1, 2'b00, 3);
    issueOp("sb",      32'h01,       32'h000000A5, 0, 1, 2'b00, 0, 0, 0, 15, 32'h0,        0, -1, 2, 32'h00,       4'b0010, 32'hA5A5A5A5, 1, 1, 32'h0,        0, 2'b00, 3);
    issueOp("mis_sh",  32'h01,       32'h1234,     0, 1, 2'b01, 0, 0, 1, 16, 32'h0,        0, -1, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0,        0, 2'b01, 1);
    issueOp("rw_both", 32'h104,      32'h0000FFFF, 1, 1, 2'b10, 0, 1, 1, 17, 32'hCAFEF00D, 0, -1, 2, 32'h104,      4'b1111, 32'h0000FFFF, 0, 1, 32'hCAFEF00D, 1, 2'b00, 3);

    repeat (4) @(negedge clk);
    check("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage load/store unit. It sits between the execute stage and the write-back data mux.
- Accepts one operation at a time from execute and drives a req/ack data-memory port for loads and stores.
- Aligns and extends load data, then presents the memory-read data and the ALU address/result to write-back together with MemToReg.
- Non-memory ops pass through with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles dm_req may wait for dm_ack before a bus error is reported (1..255).
- ADDR_W, 32: address width. Only bits [1:0] are used for lane selection.

Ports:
- clk  in  1  single clock; all state is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents an op
- ex_ready  out  1  LSU can accept; equals (state==IDLE)
- ex_addr  in  ADDR_W  ALU result / effective address
- ex_wdata  in  32  store data
- ex_mem_read  in  1  load op
- ex_mem_write  in  1  store op; mem_read and mem_write both set is treated as load
- ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ex_signed  in  1  sign-extend sub-word loads
- ex_mem_to_reg  in  1  forwarded to write-back
- ex_reg_write  in  1  forwarded to write-back
- ex_rd  in  5  destination register
- flush  in  1  synchronous kill of the in-flight op's write-back
- dm_req  out  1  memory request
- dm_we  out  1  1 = store
- dm_addr  out  ADDR_W  word-aligned address; {addr[ADDR_W-1:2], 2'b00}
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  one-cycle completion; dm_rdata valid on stores is ignored
- dm_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse per completed op
- wb_mem_read  out  32  aligned, extended load data (0 for non-loads)
- wb_addr  out  ADDR_W  captured ex_addr
- wb_mem_to_reg  out  1  captured ex_mem_to_reg
- wb_reg_write  out  1  captured ex_reg_write, forced 0 on any exception
- wb_rd  out  5  captured ex_rd
- wb_exc  out  2  00 none, 01 misaligned, 10 bus timeout

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; dm_req=0, dm_we=0, dm_be=0.
  - All wb_* outputs 0; timeout counter 0.
  - Any in-flight transaction is abandoned.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - The accept condition is ex_valid & ex_ready. On accept, capture every ex_* field.
  - Non-memory op -> DONE.
  - Misaligned (half & addr[0]; word & addr[1:0]!=0) -> DONE with exc=01, no memory request.
  - Otherwise -> ISSUE.
- ISSUE:
  - Assert dm_req with dm_addr/dm_we/dm_be/dm_wdata stable. Go to WAIT in the same cycle, holding dm_req.
  - A 1-cycle ISSUE state is allowed; dm_req rises the cycle after accept.
- WAIT:
  - Hold dm_req and all dm_* stable until dm_ack is sampled 1. On ack: dm_req=0, capture dm_rdata, -> DONE.
  - The counter increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES: dm_req=0, exc=10, -> DONE.
- DONE:
  - wb_valid=1 for exactly one cycle with the registered outputs; next state IDLE.
  - ex_ready=0 in DONE, so accept resumes the following cycle.
- Latency from accept to wb_valid:
  - Non-memory op or misaligned op: 1 cycle.
  - Memory op: 2 + (number of WAIT cycles before ack) cycles; minimum 3 with ack on the first WAIT cycle.
- Store lanes (little-endian):
  - Byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Half: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}.
  - Word: be=4'b1111.
- Load extract:
  - Select the byte or half by addr[1:0], then zero- or sign-extend per ex_signed.
- flush:
  - Sampled every cycle while the op is not yet in DONE; it sets a sticky kill bit.
  - In ISSUE/WAIT the memory transaction still completes (the bus is never aborted).
  - In DONE, a killed op produces wb_valid=0.
  - flush in IDLE with a simultaneous accept kills the accepted op.
- Outputs wb_* hold their last values outside the wb_valid cycle; consumers must qualify with wb_valid.
- dm_ack while not in WAIT is ignored.

Decomposition:
- Shared package lsu_pkg:
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - Exception codes EXC_NONE/EXC_MISALIGN/EXC_BUSTO.
  - FSM state encoding.
- Sub-module lsu_align: purely combinational.
  - Store side: be and wdata generation.
  - Load side: extract and extend.
  - Instantiated once; it holds all lane logic.

Test Plan:
- Word load, addr=0x100, dm_rdata=0xDEADBEEF, ack on the first WAIT cycle -> dm_be=1111, wb_valid 3 cycles after accept, wb_mem_read=0xDEADBEEF, wb_addr=0x100.
- Signed byte load, addr=0x103, rdata=0x80112233 -> wb_mem_read=0xFFFFFF80. Same op unsigned -> 0x00000080.
- Half store, addr=0x0A, wdata=0x0000BEEF -> dm_addr=0x08, dm_be=1100, dm_wdata=0xBEEFBEEF, dm_we=1, wb_reg_write forwarded.
- Misaligned word load, addr=0x8BADF00E -> no dm_req, wb_valid 1 cycle after accept, wb_exc=01, wb_reg_write=0.
- TIMEOUT_CYCLES=4 with ack never asserted -> dm_req drops after 4 WAIT cycles, wb_exc=10. Non-memory op with mem_to_reg=0, addr=0x8BADF00D -> wb_addr=0x8BADF00D 1 cycle after accept.
- Flush during WAIT, then ack -> transaction completes, no wb_valid. rst_n low mid-WAIT -> dm_req=0 and wb_valid=0 immediately; next op after release behaves normally.
